// File: rtl/matrix_pkg.sv
// Shared types and constants for the 3x3 matrix operand loader and its register bank.
package matrix_pkg;

   localparam int DATA_W = 8;
   localparam int N_ELEM = 18;
   localparam int A_LAST = 8;
   localparam int B_LAST = 17;
   localparam int CNT_W  = 5;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FIRE    = 2'd1,
      WAIT    = 2'd2
   } state_t;

   typedef struct packed {
      logic       is_b;
      logic [1:0] row;
      logic [1:0] col;
   } slot_pos_t;

   // Frame slot 0..17 -> which matrix, and row/col within it (row-major).
   function automatic slot_pos_t slot_pos(input logic [CNT_W-1:0] slot);
      slot_pos_t        pos;
      logic [CNT_W-1:0] idx;
      logic [CNT_W-1:0] row_full;
      logic [CNT_W-1:0] col_full;
      pos.is_b = (slot > CNT_W'(A_LAST));
      idx      = pos.is_b ? (slot - CNT_W'(A_LAST + 1)) : slot;
      row_full = idx / CNT_W'(3);
      col_full = idx - (row_full * CNT_W'(3));
      pos.row  = row_full[1:0];
      pos.col  = col_full[1:0];
      return pos;
   endfunction

endpackage

// File: rtl/matrix_operand_bank.sv
// 18-entry operand register file: one write port addressed by frame slot,
// read out in parallel as flat A and B matrices.
module matrix_operand_bank
   import matrix_pkg::*;
#(
   parameter int DATA_W = matrix_pkg::DATA_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [CNT_W-1:0]      addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [9*DATA_W-1:0]   a_flat,
   output logic [9*DATA_W-1:0]   b_flat
);

   logic [DATA_W-1:0] a_reg [3][3];
   logic [DATA_W-1:0] b_reg [3][3];
   slot_pos_t         pos;

   always_comb begin
      pos = slot_pos(addr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               a_reg[r][c] <= '0;
               b_reg[r][c] <= '0;
            end
         end
      end else if (we) begin
         if (pos.is_b) b_reg[pos.row][pos.col] <= wdata;
         else          a_reg[pos.row][pos.col] <= wdata;
      end
   end

   // Element aRC lands at bits [(3R+C)*DATA_W +: DATA_W].
   for (genvar r = 0; r < 3; r++) begin : g_row
      for (genvar c = 0; c < 3; c++) begin : g_col
         assign a_flat[(3*r+c)*DATA_W +: DATA_W] = a_reg[r][c];
         assign b_flat[(3*r+c)*DATA_W +: DATA_W] = b_reg[r][c];
      end
   end

endmodule

// File: rtl/matrix_operand_loader.sv
// Collects an 18-byte A/B operand frame from a byte stream, fires the 3x3
// multiplier and holds the operands stable until it reports done.
module matrix_operand_loader
   import matrix_pkg::*;
#(
   parameter int DATA_W = matrix_pkg::DATA_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   input  logic                  abort,
   output logic [9*DATA_W-1:0]   a_flat,
   output logic [9*DATA_W-1:0]   b_flat,
   output logic                  mult_start,
   input  logic                  mult_done,
   output logic                  busy,
   output logic                  frame_err,
   output state_t                dbg_state,
   output logic [CNT_W-1:0]      dbg_cnt
);

   // Handshake: a beat transfers on a rising edge where in_valid & in_ready;
   // in_ready depends only on state, never on in_valid, and in_last is
   // meaningful only on a transferring beat.
   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             start_next, err_next;
   logic             accept, wr_en;

   assign in_ready  = (state == COLLECT);
   assign busy      = (state != COLLECT);
   assign accept    = in_valid && in_ready;
   assign dbg_state = state;
   assign dbg_cnt   = cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= COLLECT;
         cnt        <= '0;
         mult_start <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         mult_start <= start_next;
         frame_err  <= err_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      start_next = 1'b0;
      err_next   = 1'b0;
      wr_en      = 1'b0;
      case (state)
         COLLECT: begin
            // abort wins over a coincident beat: the beat is dropped silently.
            if (abort) begin
               cnt_next = '0;
            end else if (accept) begin
               wr_en = 1'b1;
               if (cnt == CNT_W'(B_LAST)) begin
                  cnt_next = '0;
                  if (in_last) begin
                     state_next = FIRE;
                     start_next = 1'b1;
                  end else begin
                     err_next = 1'b1;
                  end
               end else if (in_last) begin
                  cnt_next = '0;
                  err_next = 1'b1;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         FIRE: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (mult_done) state_next = COLLECT;
         end
         default: begin
            state_next = COLLECT;
            cnt_next   = '0;
         end
      endcase
   end

   matrix_operand_bank #(.DATA_W(DATA_W)) u_bank (
      .clk    (clk),
      .reset  (reset),
      .we     (wr_en),
      .addr   (cnt),
      .wdata  (in_data),
      .a_flat (a_flat),
      .b_flat (b_flat)
   );

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed and randomized frames for the operand loader, checked against a
// frame-level model of the accepted bytes.
module tb_matrix_operand_loader;
   import matrix_pkg::*;

   localparam int W  = 8;
   localparam int FW = 9 * W;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [W-1:0]    in_data = '0;
   logic            in_valid = 1'b0;
   logic            in_last = 1'b0;
   logic            in_ready;
   logic            abort = 1'b0;
   logic [FW-1:0]   a_flat;
   logic [FW-1:0]   b_flat;
   logic            mult_start;
   logic            mult_done = 1'b0;
   logic            busy;
   logic            frame_err;
   state_t          dbg_state;
   logic [4:0]      dbg_cnt;

   int checks = 0;
   int errors = 0;

   // Model: register contents by slot, and bytes of the frame in progress.
   logic [W-1:0] m_mem [18];
   logic [W-1:0] exp_q [$];

   matrix_operand_loader #(.DATA_W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .abort      (abort),
      .a_flat     (a_flat),
      .b_flat     (b_flat),
      .mult_start (mult_start),
      .mult_done  (mult_done),
      .busy       (busy),
      .frame_err  (frame_err),
      .dbg_state  (dbg_state),
      .dbg_cnt    (dbg_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] pack(input int base);
      logic [FW-1:0] v;
      v = '0;
      for (int i = 0; i < 9; i++) v[i*W +: W] = m_mem[base + i];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bank();
      check("a_flat", a_flat, pack(0));
      check("b_flat", b_flat, pack(9));
   endtask

   task automatic drive_beat(input logic [W-1:0] d, input logic last, input logic ab,
                             output logic fired);
      logic err;
      err   = 1'b0;
      fired = 1'b0;
      check("in_ready_collect", FW'(in_ready), FW'(1));
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      abort    = ab;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      abort    = 1'b0;
      in_data  = '0;
      if (ab) begin
         exp_q.delete();
      end else begin
         exp_q.push_back(d);
         m_mem[exp_q.size() - 1] = d;
         if (exp_q.size() == 18) begin
            if (last) fired = 1'b1;
            else      err   = 1'b1;
            exp_q.delete();
         end else if (last) begin
            err = 1'b1;
            exp_q.delete();
         end
      end
      check("frame_err", FW'(frame_err), FW'(err));
      check("mult_start", FW'(mult_start), FW'(fired));
      check("cnt", FW'(dbg_cnt), FW'(exp_q.size()));
      check_bank();
   endtask

   // Called in the FIRE cycle or later; waits lat cycles with traffic offered, then done.
   task automatic wait_and_done(input int lat);
      check("busy_fire", FW'(busy), FW'(1));
      check("in_ready_fire", FW'(in_ready), FW'(0));
      for (int i = 0; i < lat; i++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom_range(0, 255));
         in_last  = 1'($urandom_range(0, 1));
         step();
         check("in_ready_wait", FW'(in_ready), FW'(0));
         check("busy_wait", FW'(busy), FW'(1));
         check("start_once", FW'(mult_start), FW'(0));
         check("state_wait", FW'(dbg_state), FW'(WAIT));
         check_bank();
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      mult_done = 1'b1;
      step();
      mult_done = 1'b0;
      check("in_ready_after_done", FW'(in_ready), FW'(1));
      check("busy_after_done", FW'(busy), FW'(0));
      check("state_after_done", FW'(dbg_state), FW'(COLLECT));
   endtask

   task automatic send_frame(input logic seq);
      logic f;
      for (int i = 0; i < 18; i++) begin
         drive_beat(seq ? W'(i + 1) : W'($urandom_range(0, 255)), (i == 17), 1'b0, f);
      end
      check("fired", FW'(f), FW'(1));
   endtask

   initial begin
      logic f;
      for (int i = 0; i < 18; i++) m_mem[i] = '0;

      // Reset values, with in_ready already high during reset.
      step();
      step();
      check("rst_in_ready", FW'(in_ready), FW'(1));
      check("rst_busy", FW'(busy), FW'(0));
      check("rst_start", FW'(mult_start), FW'(0));
      check("rst_err", FW'(frame_err), FW'(0));
      check("rst_cnt", FW'(dbg_cnt), FW'(0));
      check_bank();
      reset = 1'b1;
      step();

      // Frame 1..18, then hold traffic through WAIT for 10 cycles.
      send_frame(1'b1);
      check("a_seq", a_flat, 72'h090807060504030201);
      check("b_seq", b_flat, 72'h121110_0f0e0d0c0b0a);
      wait_and_done(10);

      // Early in_last on beat 5, then a clean frame from slot 0.
      for (int i = 0; i < 5; i++) drive_beat(W'($urandom_range(0, 255)), (i == 4), 1'b0, f);
      step();
      check("err_single_pulse", FW'(frame_err), FW'(0));
      check("no_start_early", FW'(mult_start), FW'(0));
      send_frame(1'b0);
      wait_and_done($urandom_range(1, 6));

      // 18 beats with no in_last.
      for (int i = 0; i < 18; i++) drive_beat(W'($urandom_range(0, 255)), 1'b0, 1'b0, f);
      check("no_start_nolast", FW'(mult_start), FW'(0));
      check("cnt_nolast", FW'(dbg_cnt), FW'(0));

      // Abort coincident with a beat after 7 beats.
      for (int i = 0; i < 7; i++) drive_beat(W'($urandom_range(0, 255)), 1'b0, 1'b0, f);
      drive_beat(W'($urandom_range(0, 255)), 1'b1, 1'b1, f);
      send_frame(1'b0);

      // done seen during FIRE must be ignored.
      mult_done = 1'b1;
      step();
      mult_done = 1'b0;
      check("done_in_fire_ignored", FW'(dbg_state), FW'(WAIT));
      check("busy_after_fire_done", FW'(busy), FW'(1));
      wait_and_done($urandom_range(1, 4));

      // Randomized frames with random multiplier latency.
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < int'($urandom_range(1, 16)); i++)
               drive_beat(W'($urandom_range(0, 255)), 1'b0, 1'b0, f);
            drive_beat(W'($urandom_range(0, 255)), 1'b0, 1'b1, f);
         end
         send_frame(1'b0);
         wait_and_done($urandom_range(1, 6));
      end

      // Asynchronous reset in WAIT.
      send_frame(1'b0);
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 18; i++) m_mem[i] = '0;
      exp_q.delete();
      check("arst_in_ready", FW'(in_ready), FW'(1));
      check("arst_busy", FW'(busy), FW'(0));
      check("arst_start", FW'(mult_start), FW'(0));
      check("arst_err", FW'(frame_err), FW'(0));
      check("arst_cnt", FW'(dbg_cnt), FW'(0));
      check("arst_state", FW'(dbg_state), FW'(COLLECT));
      check_bank();
      step();
      reset = 1'b1;
      step();
      check("post_rst_ready", FW'(in_ready), FW'(1));
      send_frame(1'b0);
      wait_and_done(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream feeder for the 3x3 matrix multiplier. Accepts the 18 operand bytes of A and B as a byte-serial valid/ready stream, holds them in a parallel register bank, and pulses `start` to the multiplier. It then keeps the operands stable until the multiplier reports `done`, and only then accepts the next frame.

## Interface
- `DATA_W`, default 8: element width; must match the multiplier operand width.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; asserting 0 forces reset state immediately.
- `in_data`  in  DATA_W  operand byte; frame order a00,a01,a02,a10..a22,b00..b22 (row-major A then row-major B).
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_last`  in  1  qualifies the final byte of a frame; sampled only on an accepted beat.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `abort`  in  1  synchronous; discards a partially collected frame.
- `a_flat`  out  9*DATA_W  A operands; element aRC at bits [(3R+C)*DATA_W +: DATA_W].
- `b_flat`  out  9*DATA_W  B operands; same packing.
- `mult_start`  out  1  one-cycle start pulse to the multiplier.
- `mult_done`  in  1  multiplier completion, level or pulse.
- `busy`  out  1  high from the start pulse until `done` is taken.
- `frame_err`  out  1  one-cycle pulse on a malformed frame.

## Operation
- States:
  - COLLECT: `in_ready`=1, `busy`=0.
  - FIRE: `mult_start`=1, `in_ready`=0, `busy`=1.
  - WAIT: `in_ready`=0, `busy`=1.
- Beat accepted when `in_valid & in_ready`. It writes slot `cnt` (0..17, 5-bit counter). Slots 0–8 go to `a_flat`, slots 9–17 go to `b_flat`.
- Accepted beat with `cnt`<17:
  - `in_last`=0: `cnt`++.
  - `in_last`=1: `frame_err` pulses, `cnt`←0, state stays COLLECT. Operand registers keep their written values but are not valid.
- Accepted beat with `cnt`=17:
  - `in_last`=1: `cnt`←0, state→FIRE.
  - `in_last`=0: `frame_err` pulses, `cnt`←0, stays COLLECT, no start.
- FIRE: one cycle, then →WAIT unconditionally.
- WAIT: when `mult_done`=1 →COLLECT. `mult_done` is ignored in COLLECT and FIRE.
- `abort`=1 in COLLECT: `cnt`←0. It takes priority over a beat accepted the same cycle; that beat is dropped and no `frame_err` is raised. `abort` is ignored in FIRE and WAIT.
- `a_flat`/`b_flat` are written only in COLLECT, so they are stable through FIRE and WAIT.
- No arithmetic besides the counter; `cnt` never exceeds 17 and never wraps.

## Timing
- Reset values: state COLLECT, `cnt`=0, `a_flat`=`b_flat`=0, `mult_start`=0, `busy`=0, `frame_err`=0. `in_ready` is decoded from state, so it reads 1 during and after reset.
- Start latency: final beat accepted at edge t → `mult_start` high for cycle t+1 → WAIT from t+2.
- Return latency: `mult_done` sampled high at edge d → `in_ready`=1 in cycle d+1.
- `mult_done` asserted already in the FIRE cycle is ignored. The loader needs `done` in WAIT; the multiplier never asserts `done` in the same cycle as `start`.
- `frame_err` and `mult_start` are registered single-cycle pulses.
- Reset asserted mid-frame or in WAIT returns to reset values at once. The multiplier shares this reset.
- Throughput: 18 beats + 1 FIRE + multiplier latency + 1 cycle per frame.

## Structure
- Shared package `matrix_pkg`:
  - `DATA_W` default.
  - `N_ELEM`=18, `A_LAST`=8, `B_LAST`=17.
  - State enum (COLLECT, FIRE, WAIT).
  - Slot-to-(matrix,row,col) index helper.
- Top level slices `a_flat`/`b_flat` onto the multiplier's individual a00..b22 ports.
- One natural sub-module: `matrix_operand_bank`, an 18×DATA_W register file with write-enable and 5-bit address, and flat A/B read ports. Control FSM and counter stay in the top.

## Test plan
- Reset then stream 1..18 with `in_last` on beat 18 → `a_flat` holds 1..9, `b_flat` holds 10..18, `mult_start` pulses exactly once one cycle later, `busy`=1.
- In WAIT, hold `in_valid`=1 for 10 cycles, then pulse `mult_done` → `in_ready`=0 throughout, operands unchanged, `in_ready`=1 the cycle after `done`.
- `in_last` on beat 5 → `frame_err` single pulse, no `mult_start`. Next full 18-beat frame starts at slot 0 and fires normally.
- 18 beats with `in_last`=0 → `frame_err` pulse, no start, `cnt` back to 0.
- After 7 beats, `abort` coincident with a valid beat → no error, beat dropped, following 18-beat frame loads correctly.
- Drop `reset` to 0 during WAIT → all outputs at reset values immediately, `in_ready`=1 after release.
